l2_input_buffers: RTL and testbench

//  Per-channel input FIFOs sitting directly upstream of the L2 input decoder.

---
 rtl/l2_input_buffers.sv | 145 ++++++++++++++
 tb/tb_l2_input_buffers.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_input_buffers.sv
// Input FIFOs in front of the L2 input decoder, one per channel.
// Every decoder-facing output is driven from registered state only.

module l2_ibuf_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push, pop;

    assign in_ready  = rst && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only pointers and count clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst) count_q <= FULL);

    a_data_stable: assert property (
        @(posedge clk) disable iff (!rst)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

endmodule

module l2_input_buffers #(
    parameter int DEPTH     = 2,
    parameter int CPU_REQ_W = 64,
    parameter int FWD_IN_W  = 36,
    parameter int RSP_IN_W  = 160,
    parameter int FLUSH_W   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l2_flush_valid,
    output logic                 l2_flush_ready,
    input  logic [FLUSH_W-1:0]   l2_flush_data,
    output logic                 l2_flush_valid_int,
    input  logic                 l2_flush_ready_int,
    output logic [FLUSH_W-1:0]   l2_flush_data_int,
    input  logic                 l2_rsp_in_valid,
    output logic                 l2_rsp_in_ready,
    input  logic [RSP_IN_W-1:0]  l2_rsp_in_data,
    output logic                 l2_rsp_in_valid_int,
    input  logic                 l2_rsp_in_ready_int,
    output logic [RSP_IN_W-1:0]  l2_rsp_in_data_int,
    input  logic                 l2_fwd_in_valid,
    output logic                 l2_fwd_in_ready,
    input  logic [FWD_IN_W-1:0]  l2_fwd_in_data,
    output logic                 l2_fwd_in_valid_int,
    input  logic                 l2_fwd_in_ready_int,
    output logic [FWD_IN_W-1:0]  l2_fwd_in_data_int,
    input  logic                 l2_cpu_req_valid,
    output logic                 l2_cpu_req_ready,
    input  logic [CPU_REQ_W-1:0] l2_cpu_req_data,
    output logic                 l2_cpu_req_valid_int,
    input  logic                 l2_cpu_req_ready_int,
    output logic [CPU_REQ_W-1:0] l2_cpu_req_data_int,
    output logic                 bufs_empty
);
    logic [3:0] empty;

    l2_ibuf_fifo #(.DEPTH(DEPTH), .W(FLUSH_W)) u_flush (
        .clk(clk), .rst(rst),
        .in_valid(l2_flush_valid), .in_ready(l2_flush_ready),
        .in_data(l2_flush_data),
        .out_valid(l2_flush_valid_int), .out_ready(l2_flush_ready_int),
        .out_data(l2_flush_data_int), .empty(empty[0])
    );

    l2_ibuf_fifo #(.DEPTH(DEPTH), .W(RSP_IN_W)) u_rsp_in (
        .clk(clk), .rst(rst),
        .in_valid(l2_rsp_in_valid), .in_ready(l2_rsp_in_ready),
        .in_data(l2_rsp_in_data),
        .out_valid(l2_rsp_in_valid_int), .out_ready(l2_rsp_in_ready_int),
        .out_data(l2_rsp_in_data_int), .empty(empty[1])
    );

    l2_ibuf_fifo #(.DEPTH(DEPTH), .W(FWD_IN_W)) u_fwd_in (
        .clk(clk), .rst(rst),
        .in_valid(l2_fwd_in_valid), .in_ready(l2_fwd_in_ready),
        .in_data(l2_fwd_in_data),
        .out_valid(l2_fwd_in_valid_int), .out_ready(l2_fwd_in_ready_int),
        .out_data(l2_fwd_in_data_int), .empty(empty[2])
    );

    l2_ibuf_fifo #(.DEPTH(DEPTH), .W(CPU_REQ_W)) u_cpu_req (
        .clk(clk), .rst(rst),
        .in_valid(l2_cpu_req_valid), .in_ready(l2_cpu_req_ready),
        .in_data(l2_cpu_req_data),
        .out_valid(l2_cpu_req_valid_int), .out_ready(l2_cpu_req_ready_int),
        .out_data(l2_cpu_req_data_int), .empty(empty[3])
    );

    assign bufs_empty = &empty;

endmodule

// File: tb/tb_l2_input_buffers.sv
// Bench for l2_input_buffers: queue scoreboard per channel plus a
// vector table for the fwd_in full-boundary sequence.

module tb_l2_input_buffers;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vld  [4];
    logic         rint [4];
    logic [159:0] dat  [4];
    logic         rdy  [4];
    logic         vint [4];
    logic [159:0] dint [4];
    logic         bufs_empty;

    logic         flush_ready, flush_vint;
    logic [0:0]   flush_dint;
    logic         rsp_ready, rsp_vint;
    logic [159:0] rsp_dint;
    logic         fwd_ready, fwd_vint;
    logic [35:0]  fwd_dint;
    logic         cpu_ready, cpu_vint;
    logic [63:0]  cpu_dint;

    l2_input_buffers dut (
        .clk(clk), .rst(rst),
        .l2_flush_valid(vld[0]), .l2_flush_ready(flush_ready),
        .l2_flush_data(dat[0][0:0]),
        .l2_flush_valid_int(flush_vint), .l2_flush_ready_int(rint[0]),
        .l2_flush_data_int(flush_dint),
        .l2_rsp_in_valid(vld[1]), .l2_rsp_in_ready(rsp_ready),
        .l2_rsp_in_data(dat[1]),
        .l2_rsp_in_valid_int(rsp_vint), .l2_rsp_in_ready_int(rint[1]),
        .l2_rsp_in_data_int(rsp_dint),
        .l2_fwd_in_valid(vld[2]), .l2_fwd_in_ready(fwd_ready),
        .l2_fwd_in_data(dat[2][35:0]),
        .l2_fwd_in_valid_int(fwd_vint), .l2_fwd_in_ready_int(rint[2]),
        .l2_fwd_in_data_int(fwd_dint),
        .l2_cpu_req_valid(vld[3]), .l2_cpu_req_ready(cpu_ready),
        .l2_cpu_req_data(dat[3][63:0]),
        .l2_cpu_req_valid_int(cpu_vint), .l2_cpu_req_ready_int(rint[3]),
        .l2_cpu_req_data_int(cpu_dint),
        .bufs_empty(bufs_empty)
    );

    assign rdy[0]  = flush_ready;
    assign rdy[1]  = rsp_ready;
    assign rdy[2]  = fwd_ready;
    assign rdy[3]  = cpu_ready;
    assign vint[0] = flush_vint;
    assign vint[1] = rsp_vint;
    assign vint[2] = fwd_vint;
    assign vint[3] = cpu_vint;
    assign dint[0] = {159'd0, flush_dint};
    assign dint[1] = rsp_dint;
    assign dint[2] = {124'd0, fwd_dint};
    assign dint[3] = {96'd0, cpu_dint};

    int tests = 0;
    int fails = 0;

    logic [159:0] q0 [$];
    logic [159:0] q1 [$];
    logic [159:0] q2 [$];
    logic [159:0] q3 [$];

    function automatic int sz(int ch);
        case (ch)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [159:0] front(int ch);
        case (ch)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    function automatic logic [159:0] mask(int ch, logic [159:0] d);
        case (ch)
            0: return {159'd0, d[0]};
            1: return d;
            2: return {124'd0, d[35:0]};
            default: return {96'd0, d[63:0]};
        endcase
    endfunction

    task automatic sb_push(int ch, logic [159:0] d);
        case (ch)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic sb_pop(int ch);
        case (ch)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: check outputs against the queue model, then advance the model.
    task automatic cyc();
        bit all_empty;
        #1;
        all_empty = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            bit e_rdy, e_vint;
            e_rdy  = rst && (sz(ch) != DEPTH);
            e_vint = (sz(ch) != 0);
            if (e_vint) all_empty = 1'b0;
            chk($sformatf("ready ch%0d", ch), {159'd0, rdy[ch]}, {159'd0, e_rdy});
            chk($sformatf("valid_int ch%0d", ch), {159'd0, vint[ch]},
                {159'd0, e_vint});
            if (e_vint)
                chk($sformatf("data_int ch%0d", ch), dint[ch], front(ch));
            if (rst) begin
                if (e_vint && rint[ch]) sb_pop(ch);
                if (vld[ch] && e_rdy) sb_push(ch, mask(ch, dat[ch]));
            end
        end
        chk("bufs_empty", {159'd0, bufs_empty}, {159'd0, all_empty});
        if (!rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
            q3.delete();
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          v;
        logic [35:0] d;
        bit          ri;
        bit          e_rdy;
        bit          e_vint;
        logic [35:0] e_d;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1, 36'hA, 0, 1, 0, 36'h0};
        tbl[1] = '{1, 36'hB, 0, 1, 1, 36'hA};
        tbl[2] = '{1, 36'hC, 0, 0, 1, 36'hA};
        tbl[3] = '{1, 36'hC, 1, 0, 1, 36'hA};
        tbl[4] = '{1, 36'hC, 0, 1, 1, 36'hB};
        tbl[5] = '{0, 36'h0, 1, 0, 1, 36'hB};
        tbl[6] = '{0, 36'h0, 1, 1, 1, 36'hC};
        tbl[7] = '{0, 36'h0, 0, 1, 0, 36'h0};

        rst = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            vld[ch]  = 1'b0;
            rint[ch] = 1'b0;
            dat[ch]  = '0;
        end
        @(posedge clk);
        #1;

        // reset then idle
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("post_rst ready ch%0d", ch), {159'd0, rdy[ch]}, 160'd1);
            chk($sformatf("post_rst vint ch%0d", ch), {159'd0, vint[ch]}, 160'd0);
        end
        chk("post_rst bufs_empty", {159'd0, bufs_empty}, 160'd1);
        cyc();

        // single cpu_req push and pop
        vld[3] = 1'b1;
        dat[3] = 160'h1234;
        cyc();
        vld[3] = 1'b0;
        chk("cpu single vint", {159'd0, vint[3]}, 160'd1);
        chk("cpu single data", dint[3], 160'h1234);
        rint[3] = 1'b1;
        cyc();
        rint[3] = 1'b0;
        chk("cpu single drained", {159'd0, vint[3]}, 160'd0);
        chk("cpu single empty", {159'd0, bufs_empty}, 160'd1);

        // fwd_in full boundary, table driven
        for (int i = 0; i < 8; i++) begin
            vld[2]  = tbl[i].v;
            dat[2]  = {124'd0, tbl[i].d};
            rint[2] = tbl[i].ri;
            #1;
            chk($sformatf("tbl%0d ready", i), {159'd0, rdy[2]},
                {159'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d vint", i), {159'd0, vint[2]},
                {159'd0, tbl[i].e_vint});
            if (tbl[i].e_vint)
                chk($sformatf("tbl%0d data", i), dint[2], {124'd0, tbl[i].e_d});
            cyc();
        end
        vld[2]  = 1'b0;
        rint[2] = 1'b0;

        // rsp_in streaming at count 1 across pointer wraps
        vld[1] = 1'b1;
        dat[1] = '0;
        cyc();
        for (int i = 1; i <= 10; i++) begin
            dat[1]  = 160'(i);
            rint[1] = 1'b1;
            #1;
            chk($sformatf("stream%0d ready", i), {159'd0, rdy[1]}, 160'd1);
            chk($sformatf("stream%0d vint", i), {159'd0, vint[1]}, 160'd1);
            chk($sformatf("stream%0d data", i), dint[1], 160'(i - 1));
            cyc();
        end
        vld[1] = 1'b0;
        cyc();
        rint[1] = 1'b0;
        cyc();
        chk("stream drained", {159'd0, vint[1]}, 160'd0);

        // all four channels at once, pop only flush
        dat[0] = 160'd1;
        dat[1] = {32'hCAFE_F00D, 128'h5555_AAAA_0123_4567_89AB_CDEF_1357_9BDF};
        dat[2] = 160'h9_0000_0001;
        dat[3] = 160'hDEAD_BEEF_0000_0005;
        for (int ch = 0; ch < 4; ch++) vld[ch] = 1'b1;
        cyc();
        for (int ch = 0; ch < 4; ch++) vld[ch] = 1'b0;
        for (int ch = 0; ch < 4; ch++)
            chk($sformatf("all4 vint ch%0d", ch), {159'd0, vint[ch]}, 160'd1);
        rint[0] = 1'b1;
        cyc();
        rint[0] = 1'b0;
        chk("all4 flush popped", {159'd0, vint[0]}, 160'd0);
        chk("all4 rsp kept", {159'd0, vint[1]}, 160'd1);
        chk("all4 fwd kept", {159'd0, vint[2]}, 160'd1);
        chk("all4 cpu kept", {159'd0, vint[3]}, 160'd1);
        chk("all4 not empty", {159'd0, bufs_empty}, 160'd0);
        for (int ch = 0; ch < 4; ch++) rint[ch] = 1'b1;
        cyc();
        for (int ch = 0; ch < 4; ch++) rint[ch] = 1'b0;
        cyc();
        chk("all4 drained", {159'd0, bufs_empty}, 160'd1);

        // reset mid-operation drops everything
        vld[3] = 1'b1;
        dat[3] = 160'h111;
        cyc();
        dat[3] = 160'h222;
        vld[2] = 1'b1;
        dat[2] = 160'h333;
        cyc();
        rst = 1'b0;
        dat[3] = 160'h444;
        for (int ch = 0; ch < 4; ch++) begin
            vld[ch]  = 1'b1;
            rint[ch] = 1'b1;
        end
        cyc();
        for (int ch = 0; ch < 4; ch++) begin
            vld[ch]  = 1'b0;
            rint[ch] = 1'b0;
            chk($sformatf("midrst vint ch%0d", ch), {159'd0, vint[ch]}, 160'd0);
        end
        chk("midrst empty", {159'd0, bufs_empty}, 160'd1);
        rst = 1'b1;
        cyc();
        vld[3] = 1'b1;
        dat[3] = 160'h555;
        cyc();
        vld[3] = 1'b0;
        chk("midrst no leak", dint[3], 160'h555);
        rint[3] = 1'b1;
        cyc();
        rint[3] = 1'b0;
        cyc();
        chk("final empty", {159'd0, bufs_empty}, 160'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
